mem_dbus_ctrl: RTL and testbench

- MEM-stage data-bus controller, directly downstream of the EX/MEM pipeline register.
- Consumes the registered memory request of pipe A (ce/we/addr/wdata plus access size) and checks alignment.
- Drives a request/grant/rvalid data bus with byte enables, then returns the aligned and extended load data to MEM.
- Holds the pipeline through stall_req until the access completes, and raises AdEL/AdES/DBE exception flags.

---
 rtl/mem_dbus_ctrl_pkg.sv | 37 +++
 rtl/mem_align_unit.sv | 65 ++++++
 rtl/mem_dbus_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mem_dbus_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dbus_ctrl_pkg.sv
// cpu_defs: shared types for the MEM-stage data-bus controller.
//   MemSize_t   - access size (byte/half/word)
//   DbusState_t - bus controller state
//   DBusReq_t   - registered bus request fields
//   decode_size - maps the 2-bit size field to MemSize_t (2'b11 -> WORD)
package cpu_defs;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } MemSize_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } DbusState_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } DBusReq_t;

  function automatic MemSize_t decode_size(input logic [1:0] sz);
    case (sz)
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_align_unit.sv
// mem_align_unit: combinational lane steering for the data bus.
//   Store side : i_st_size/i_st_addr_lo/i_st_wdata -> o_be, o_wdata, o_misaligned
//   Load side  : i_ld_size/i_ld_addr_lo/i_ld_signed/i_rdata -> o_load_data
//                (lane select plus sign/zero extension)
module mem_align_unit
  import cpu_defs::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_wdata,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic        i_ld_signed,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_misaligned
);

  MemSize_t    w_st_size;
  MemSize_t    w_ld_size;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_st_size    = decode_size(i_st_size);
    o_be         = 4'b1111;
    o_wdata      = i_st_wdata;
    o_misaligned = 1'b0;
    case (w_st_size)
      BYTE: begin
        o_be    = 4'b0001 << i_st_addr_lo;
        o_wdata = {4{i_st_wdata[7:0]}};
      end
      HALF: begin
        o_be         = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_st_wdata[15:0]}};
        o_misaligned = i_st_addr_lo[0];
      end
      default: begin
        o_be         = 4'b1111;
        o_wdata      = i_st_wdata;
        o_misaligned = |i_st_addr_lo;
      end
    endcase
  end

  always_comb begin
    w_ld_size = decode_size(i_ld_size);
    case (i_ld_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (w_ld_size)
      BYTE:    o_load_data = {{24{i_ld_signed & w_byte[7]}}, w_byte};
      HALF:    o_load_data = {{16{i_ld_signed & w_half[15]}}, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_dbus_ctrl.sv
// mem_dbus_ctrl: MEM-stage data-bus controller.
//   Pipeline side : mem_ce/we/addr/wdata/size/signed, except_in, flush, pipe_stall
//                   -> load_data, done, stall_req, except_adel/ades/dbe, badvaddr
//   Bus side      : dbus_req/we/addr/be/wdata -> dbus_gnt, dbus_rvalid, dbus_rdata
//   rst is asynchronous, active-low.
module mem_dbus_ctrl
  import cpu_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic        except_in,
  input  logic        flush,
  input  logic        pipe_stall,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic [31:0] load_data,
  output logic        done,
  output logic        stall_req,
  output logic        except_adel,
  output logic        except_ades,
  output logic        except_dbe,
  output logic [31:0] badvaddr
);

  localparam logic [CNT_WIDTH-1:0] LP_TIMEOUT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam bit                   LP_TO_EN   = (TIMEOUT_CYCLES != 0);

  DbusState_t           r_state,   w_state_nxt;
  logic                 r_drop,    w_drop_nxt;
  logic [CNT_WIDTH-1:0] r_cnt,     w_cnt_nxt;
  DBusReq_t             r_bus,     w_bus_nxt;
  MemSize_t             r_size,    w_size_nxt;
  logic                 r_signed,  w_signed_nxt;
  logic [1:0]           r_addr_lo, w_addr_lo_nxt;
  logic [31:0]          r_load,    w_load_nxt;
  logic                 r_dbe,     w_dbe_nxt;

  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic                 w_timeout;
  logic                 w_start;
  logic                 w_misaligned;
  logic [3:0]           w_be;
  logic [31:0]          w_wdata;
  logic [31:0]          w_ld_ext;

  // Store side follows the live request; load side uses the latched request.
  mem_align_unit u_align (
    .i_st_size    (mem_size),
    .i_st_addr_lo (mem_addr[1:0]),
    .i_st_wdata   (mem_wdata),
    .i_ld_size    (r_size),
    .i_ld_addr_lo (r_addr_lo),
    .i_ld_signed  (r_signed),
    .i_rdata      (dbus_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_ld_ext),
    .o_misaligned (w_misaligned)
  );

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = LP_TO_EN && (w_cnt_inc == LP_TIMEOUT);
  assign w_start   = (r_state == IDLE) & mem_ce & ~w_misaligned & ~except_in & ~flush;

  always_comb begin
    w_state_nxt   = r_state;
    w_drop_nxt    = r_drop;
    w_cnt_nxt     = r_cnt;
    w_bus_nxt     = r_bus;
    w_size_nxt    = r_size;
    w_signed_nxt  = r_signed;
    w_addr_lo_nxt = r_addr_lo;
    w_load_nxt    = r_load;
    w_dbe_nxt     = r_dbe;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt     = REQ;
          w_cnt_nxt       = '0;
          w_dbe_nxt       = 1'b0;
          w_bus_nxt.we    = mem_we;
          w_bus_nxt.addr  = {mem_addr[31:2], 2'b00};
          w_bus_nxt.be    = w_be;
          w_bus_nxt.wdata = w_wdata;
          w_size_nxt      = decode_size(mem_size);
          w_signed_nxt    = mem_signed;
          w_addr_lo_nxt   = mem_addr[1:0];
        end
      end
      REQ: begin
        // A grant in the flush cycle still counts: loads must drain their rvalid.
        if (dbus_gnt) begin
          if (r_bus.we) begin
            w_state_nxt = flush ? IDLE : DONE;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = '0;
            w_drop_nxt  = flush;
          end
        end else if (flush) begin
          w_state_nxt = IDLE;
        end else if (w_timeout) begin
          w_state_nxt = DONE;
          w_dbe_nxt   = 1'b1;
          w_load_nxt  = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      WAIT: begin
        if (dbus_rvalid) begin
          if (r_drop || flush) begin
            w_state_nxt = IDLE;
            w_drop_nxt  = 1'b0;
          end else begin
            w_state_nxt = DONE;
            w_load_nxt  = w_ld_ext;
          end
        end else if (!r_drop) begin
          if (flush) begin
            w_drop_nxt = 1'b1;
          end else if (w_timeout) begin
            w_state_nxt = DONE;
            w_dbe_nxt   = 1'b1;
            w_load_nxt  = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: begin
        if (flush || !pipe_stall) begin
          w_state_nxt = IDLE;
        end
      end
    endcase
    w_bus_nxt.req = (w_state_nxt == REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_drop    <= 1'b0;
      r_cnt     <= '0;
      r_bus     <= '0;
      r_size    <= BYTE;
      r_signed  <= 1'b0;
      r_addr_lo <= 2'b00;
      r_load    <= '0;
      r_dbe     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_drop    <= w_drop_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bus     <= w_bus_nxt;
      r_size    <= w_size_nxt;
      r_signed  <= w_signed_nxt;
      r_addr_lo <= w_addr_lo_nxt;
      r_load    <= w_load_nxt;
      r_dbe     <= w_dbe_nxt;
    end
  end

  assign dbus_req    = r_bus.req;
  assign dbus_we     = r_bus.we;
  assign dbus_addr   = r_bus.addr;
  assign dbus_be     = r_bus.be;
  assign dbus_wdata  = r_bus.wdata;
  assign load_data   = r_load;
  assign done        = (r_state == DONE);
  assign except_dbe  = done & r_dbe;
  assign except_adel = mem_ce & ~except_in & w_misaligned & ~mem_we;
  assign except_ades = mem_ce & ~except_in & w_misaligned & mem_we;
  assign badvaddr    = mem_addr;

  // While a dropped read drains, any newly presented instruction must wait.
  assign stall_req = (((r_state == REQ) || (r_state == WAIT)) && !r_drop)
                   || w_start
                   || (r_drop && mem_ce);

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Self-checking bench for mem_dbus_ctrl (TIMEOUT_CYCLES=4).
module tb_mem_dbus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce, mem_we, mem_signed, except_in, flush, pipe_stall;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic [31:0] load_data, badvaddr;
  logic        done, stall_req, except_adel, except_ades, except_dbe;

  int n_checks = 0;
  int n_errors = 0;

  // model state: the access the bench believes is live
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [1:0]  m_size;
  logic        m_sg, m_we, m_live;

  // per-access results
  logic [31:0] res_ld, res_wd;
  logic [3:0]  res_be;
  logic        res_dbe;
  int          res_stall, res_req_cyc, res_gnt_cyc, res_done_cyc, res_done_cnt;

  always #5 clk = ~clk;

  mem_dbus_ctrl #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_signed(mem_signed), .except_in(except_in),
    .flush(flush), .pipe_stall(pipe_stall),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
    .dbus_rdata(dbus_rdata), .load_data(load_data), .done(done), .stall_req(stall_req),
    .except_adel(except_adel), .except_ades(except_ades), .except_dbe(except_dbe),
    .badvaddr(badvaddr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- reference rules, expressed arithmetically ----
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_mis(input logic [31:0] a, input logic [1:0] sz);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
    int n;
    n = nbytes(sz);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wd(input logic [31:0] wd, input logic [1:0] sz);
    int n;
    n = nbytes(sz);
    if (n == 1) return (wd % 256) * 32'h01010101;
    if (n == 2) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_ld(input logic [31:0] rd, input logic [31:0] a,
                                       input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    if (n == 4) return rd;
    v = (rd >> (8 * (a % 4))) % (32'd1 << (8 * n));
    if (sg && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  // ---- per-cycle comparison against the model ----
  always @(negedge clk) begin
    chk("badvaddr", badvaddr, mem_addr);
    if (rst) begin
      chk("adel", 32'(except_adel), 32'(mem_ce && !except_in && !mem_we && m_mis(mem_addr, mem_size)));
      chk("ades", 32'(except_ades), 32'(mem_ce && !except_in && mem_we && m_mis(mem_addr, mem_size)));
      if (!m_live) begin
        chk("no_bus_req", 32'(dbus_req), 32'd0);
      end else if (dbus_req) begin
        chk("dbus_addr", dbus_addr, m_addr & 32'hFFFFFFFC);
        chk("dbus_be", 32'(dbus_be), 32'(m_be(m_addr, m_size)));
        chk("dbus_we", 32'(dbus_we), 32'(m_we));
        if (m_we) chk("dbus_wdata", dbus_wdata, m_wd(m_wdata, m_size));
      end
      if (done) begin
        if (except_dbe) chk("dbe_load_zero", load_data, 32'd0);
        else if (!m_we) chk("load_data", load_data, m_ld(m_rdata, m_addr, m_size, m_sg));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access from IDLE; simple bus responder inside. gnt_wait=0 means never grant.
  task automatic access(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                        input logic we, input logic [31:0] wd, input int gnt_wait,
                        input int rv_wait, input logic [31:0] rd, input int hold);
    int  req_n, wait_n;
    bit  granted, leave;
    mem_ce = 1'b1; mem_we = we; mem_addr = a; mem_size = sz; mem_signed = sg;
    mem_wdata = wd; except_in = 1'b0; flush = 1'b0;
    m_addr = a; m_size = sz; m_sg = sg; m_we = we; m_wdata = wd; m_live = 1'b1;
    res_ld = '0; res_wd = '0; res_be = '0; res_dbe = 1'b0;
    res_stall = 0; res_gnt_cyc = -1; res_done_cyc = -1; res_done_cnt = 0;
    req_n = 0; wait_n = 0; granted = 0; leave = 0;
    for (int c = 0; c < 40 && !leave; c++) begin
      dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
      pipe_stall = (res_done_cnt < hold);
      if (dbus_req) begin
        req_n++;
        if (req_n == gnt_wait) dbus_gnt = 1'b1;
      end else if (granted && !we) begin
        wait_n++;
        if (wait_n == rv_wait) begin
          dbus_rvalid = 1'b1; dbus_rdata = rd; m_rdata = rd;
        end
      end
      @(negedge clk);
      if (stall_req) res_stall++;
      if (dbus_req) begin res_be = dbus_be; res_wd = dbus_wdata; end
      if (dbus_gnt) begin granted = 1; res_gnt_cyc = c; end
      if (done) begin
        if (res_done_cnt == 0) begin
          res_done_cyc = c; res_ld = load_data; res_dbe = except_dbe;
        end
        res_done_cnt++;
        if (!pipe_stall) leave = 1;
      end
      tick();
    end
    res_req_cyc = req_n;
    chk("access_completed", 32'(leave), 32'd1);
    mem_ce = 1'b0; pipe_stall = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0; m_live = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; mem_ce = 0; mem_we = 0; mem_signed = 0; except_in = 0; flush = 0;
    pipe_stall = 0; mem_addr = 32'h12345678; mem_wdata = '0; mem_size = 2'b10;
    dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = '0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_size = '0; m_sg = 0; m_we = 0; m_live = 0;

    repeat (2) tick();
    @(negedge clk);
    chk("rst_req", 32'(dbus_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_load", load_data, 32'd0);
    chk("rst_dbe", 32'(except_dbe), 32'd0);
    chk("rst_be", 32'(dbus_be), 32'd0);
    chk("rst_badvaddr", badvaddr, 32'h12345678);
    tick(); rst = 1'b1;
    repeat (2) tick();

    // word load, grant on 2nd request cycle, rvalid one cycle later
    access(32'h80000004, 2'b10, 1'b0, 1'b0, 32'h0, 2, 1, 32'hDEADBEEF, 0);
    chk("t1_load", res_ld, 32'hDEADBEEF);
    chk("t1_be", 32'(res_be), 32'hF);
    chk("t1_stall_cycles", 32'(res_stall), 32'd4);
    chk("t1_done_cycle", 32'(res_done_cyc), 32'd4);

    access(32'h80000003, 2'b00, 1'b1, 1'b0, 32'h0, 1, 1, 32'h80FF1234, 0);
    chk("t2_sbyte", res_ld, 32'hFFFFFF80);
    chk("t2_be", 32'(res_be), 32'h8);
    access(32'h80000002, 2'b01, 1'b0, 1'b0, 32'h0, 1, 1, 32'h80FF1234, 0);
    chk("t2_uhalf", res_ld, 32'h000080FF);
    access(32'h80000002, 2'b01, 1'b1, 1'b0, 32'h0, 1, 2, 32'h80FF1234, 0);
    chk("t2_shalf", res_ld, 32'hFFFF80FF);
    access(32'h80000009, 2'b00, 1'b0, 1'b0, 32'h0, 1, 1, 32'h80FF1234, 0);
    chk("t2_ubyte_lane1", res_ld, 32'h00000012);
    access(32'h80000008, 2'b11, 1'b1, 1'b0, 32'h0, 3, 1, 32'hCAFEF00D, 0);
    chk("t2_size11_word", res_ld, 32'hCAFEF00D);

    // half store, DONE held two extra cycles by pipe_stall
    access(32'h80000002, 2'b01, 1'b0, 1'b1, 32'hABCD1234, 1, 1, 32'h0, 2);
    chk("t3_be", 32'(res_be), 32'hC);
    chk("t3_wdata", res_wd, 32'h12341234);
    chk("t3_done_after_gnt", 32'(res_done_cyc), 32'(res_gnt_cyc + 1));
    chk("t3_done_hold", 32'(res_done_cnt), 32'd3);
    chk("t3_single_issue", 32'(res_req_cyc), 32'd1);
    access(32'h80000001, 2'b00, 1'b0, 1'b1, 32'h000000A5, 1, 1, 32'h0, 0);
    chk("t3_byte_wdata", res_wd, 32'hA5A5A5A5);

    // misaligned accesses, then suppressed by an older exception
    mem_ce = 1; mem_we = 0; mem_addr = 32'h80000001; mem_size = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_adel", 32'(except_adel), 32'd1);
      chk("t4_badvaddr", badvaddr, 32'h80000001);
      chk("t4_stall", 32'(stall_req), 32'd0);
      tick();
    end
    except_in = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t4_exin_adel", 32'(except_adel), 32'd0);
      chk("t4_exin_stall", 32'(stall_req), 32'd0);
      tick();
    end
    except_in = 0; mem_we = 1; mem_addr = 32'h80000003; mem_size = 2'b01;
    @(negedge clk);
    chk("t4_ades", 32'(except_ades), 32'd1);
    chk("t4_ades_no_adel", 32'(except_adel), 32'd0);
    tick(); mem_ce = 0; mem_we = 0;
    tick();

    // flush while a load waits for rvalid; a new load follows
    mem_ce = 1; mem_addr = 32'h00000100; mem_size = 2'b10;
    m_addr = 32'h00000100; m_size = 2'b10; m_we = 0; m_sg = 0; m_live = 1;
    tick(); dbus_gnt = 1;
    @(negedge clk); chk("t5_req", 32'(dbus_req), 32'd1);
    tick(); dbus_gnt = 0; flush = 1;
    @(negedge clk); chk("t5_stall_wait", 32'(stall_req), 32'd1);
    tick(); flush = 0; mem_addr = 32'h00000204;
    @(negedge clk);
    chk("t5_stall_drop", 32'(stall_req), 32'd1);
    chk("t5_no_done", 32'(done), 32'd0);
    chk("t5_no_reissue", 32'(dbus_req), 32'd0);
    tick(); dbus_rvalid = 1; dbus_rdata = 32'h11111111;
    @(negedge clk);
    chk("t5_stall_rv", 32'(stall_req), 32'd1);
    chk("t5_no_done_rv", 32'(done), 32'd0);
    tick(); dbus_rvalid = 0;
    access(32'h00000204, 2'b10, 1'b0, 1'b0, 32'h0, 1, 1, 32'h22222222, 0);
    chk("t5_second_load", res_ld, 32'h22222222);
    chk("t5_second_stall", 32'(res_stall), 32'd3);

    // flush in REQ before grant aborts
    mem_ce = 1; mem_addr = 32'h00000300; m_addr = 32'h00000300; m_live = 1;
    tick(); flush = 1;
    @(negedge clk); chk("t6_req", 32'(dbus_req), 32'd1);
    tick(); flush = 0; mem_ce = 0; m_live = 0;
    @(negedge clk);
    chk("t6_abort_req", 32'(dbus_req), 32'd0);
    chk("t6_abort_done", 32'(done), 32'd0);
    repeat (2) tick();

    // grant never arrives
    access(32'h00000400, 2'b10, 1'b0, 1'b0, 32'h0, 0, 1, 32'h0, 0);
    chk("t7_req_cycles", 32'(res_req_cyc), 32'd4);
    chk("t7_dbe", 32'(res_dbe), 32'd1);
    chk("t7_load_zero", res_ld, 32'd0);
    chk("t7_done_cycle", 32'(res_done_cyc), 32'd5);

    // asynchronous reset in the middle of REQ
    mem_ce = 1; mem_addr = 32'h00000500; m_addr = 32'h00000500; m_live = 1;
    tick();
    @(negedge clk); chk("t8_req", 32'(dbus_req), 32'd1);
    @(posedge clk); #2;
    rst = 0; mem_ce = 0; m_live = 0;
    #1;
    chk("t8_async_req", 32'(dbus_req), 32'd0);
    chk("t8_async_done", 32'(done), 32'd0);
    tick(); rst = 1;
    repeat (2) tick();
    @(negedge clk); chk("t8_idle_after", 32'(dbus_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
